// File: rtl/wvb_reader_pkg.sv
// Shared waveform-buffer definitions: header bundle layout,
// reader state encoding and the output-buffer credit rule.
package wvb_reader_pkg;

  localparam int HDR_W  = 80;
  localparam int LTC_W  = 48;
  localparam int ADR_W  = 12;
  localparam int TRIG_W = 2;
  localparam int PRE_W  = 5;

  localparam int PRE_LSB   = 0;
  localparam int CNST_LSB  = 5;
  localparam int TRIG_LSB  = 6;
  localparam int STOP_LSB  = 8;
  localparam int START_LSB = 20;
  localparam int LTC_LSB   = 32;

  typedef struct packed {
    logic [LTC_W-1:0]  evt_ltc;
    logic [ADR_W-1:0]  start_addr;
    logic [ADR_W-1:0]  stop_addr;
    logic [TRIG_W-1:0] trig_src;
    logic              cnst_run;
    logic [PRE_W-1:0]  pre_conf;
  } hdr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } rd_state_t;

  // A new address may go out only if the 2-entry buffer will still
  // have room once the word already in flight has landed.
  function automatic logic can_issue(
    input logic [1:0] level,
    input logic       inflight,
    input logic       pop
  );
    return ({1'b0, level} + {2'b0, inflight})
           <= (3'd1 + {2'b0, pop});
  endfunction

endpackage

// File: rtl/mDOM_wvb_hdr_bundle_0_fan_out.sv
// Splits a waveform-buffer header bundle into its fields.
// Pure wiring; offsets come from the shared package.
module mDOM_wvb_hdr_bundle_0_fan_out
  import wvb_reader_pkg::*;
(
  input  logic [HDR_W-1:0]  bundle,
  output logic [LTC_W-1:0]  evt_ltc,
  output logic [ADR_W-1:0]  start_addr,
  output logic [ADR_W-1:0]  stop_addr,
  output logic [TRIG_W-1:0] trig_src,
  output logic              cnst_run,
  output logic [PRE_W-1:0]  pre_conf
);

  assign evt_ltc    = bundle[LTC_LSB   +: LTC_W];
  assign start_addr = bundle[START_LSB +: ADR_W];
  assign stop_addr  = bundle[STOP_LSB  +: ADR_W];
  assign trig_src   = bundle[TRIG_LSB  +: TRIG_W];
  assign cnst_run   = bundle[CNST_LSB];
  assign pre_conf   = bundle[PRE_LSB   +: PRE_W];

endmodule

// File: rtl/wvb_reader_skid.sv
// wvb_rd_skid: 2-entry valid/ready buffer that absorbs the one-cycle
// RAM latency; the producer is credit-limited via level.
module wvb_rd_skid #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   level
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  assign push      = in_valid;
  assign pop       = out_ready && (cnt != 2'd0);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = ent0;
  assign level     = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= in_data;
          else             ent1 <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= in_data;
          end else begin
            ent0 <= ent1;
            ent1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/wvb_reader.sv
// Waveform buffer reader: streams one event per header from the
// buffer RAM, then releases the space and pops the header FIFO.
module wvb_reader
  import wvb_reader_pkg::*;
#(
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_HDR_WIDTH  = 80,
  parameter int P_DATA_WIDTH = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data,
  output logic                    hdr_rdreq,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  input  logic [P_DATA_WIDTH-1:0] wvb_data,
  output logic                    wvb_rddone,
  output logic [P_HDR_WIDTH-1:0]  evt_hdr,
  output logic [P_DATA_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sop,
  output logic                    out_eop
);

  localparam int SW = P_DATA_WIDTH + 2;

  rd_state_t state;

  logic              first;
  logic              rd_vld;
  logic              rd_sop;
  logic              rd_eop;
  logic              pop;
  logic              adv;
  logic              stop_hit;
  logic [1:0]        level;
  logic [SW-1:0]     skid_out;

  logic [LTC_W-1:0]  in_ltc;
  logic [ADR_W-1:0]  in_start;
  logic [ADR_W-1:0]  in_stop;
  logic [TRIG_W-1:0] in_trig;
  logic              in_cnst;
  logic [PRE_W-1:0]  in_pre;

  logic [LTC_W-1:0]  ev_ltc;
  logic [ADR_W-1:0]  ev_start;
  logic [ADR_W-1:0]  ev_stop;
  logic [TRIG_W-1:0] ev_trig;
  logic              ev_cnst;
  logic [PRE_W-1:0]  ev_pre;
  logic              unused_hdr;

  mDOM_wvb_hdr_bundle_0_fan_out u_hdr_in (
    .bundle     (HDR_W'(hdr_data)),
    .evt_ltc    (in_ltc),
    .start_addr (in_start),
    .stop_addr  (in_stop),
    .trig_src   (in_trig),
    .cnst_run   (in_cnst),
    .pre_conf   (in_pre)
  );

  mDOM_wvb_hdr_bundle_0_fan_out u_hdr_ev (
    .bundle     (HDR_W'(evt_hdr)),
    .evt_ltc    (ev_ltc),
    .start_addr (ev_start),
    .stop_addr  (ev_stop),
    .trig_src   (ev_trig),
    .cnst_run   (ev_cnst),
    .pre_conf   (ev_pre)
  );

  assign unused_hdr = ^{in_ltc, in_stop, in_trig, in_cnst,
                        in_pre, ev_ltc, ev_start, ev_trig,
                        ev_cnst, ev_pre};

  assign pop      = out_valid && out_ready;
  assign adv      = (state == S_READ)
                    && can_issue(level, rd_vld, pop);
  assign stop_hit = (wvb_rd_addr == P_ADR_WIDTH'(ev_stop));

  wvb_rd_skid #(.W(SW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({rd_sop, rd_eop, wvb_data}),
    .in_valid  (rd_vld),
    .out_data  (skid_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  assign {out_sop, out_eop, out_data} = skid_out;

  // Stop is an address match, so a wrapped full-buffer event
  // (start = stop + 1) naturally reads every location once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wvb_rd_addr <= '0;
      evt_hdr     <= '0;
      first       <= 1'b0;
      rd_vld      <= 1'b0;
      rd_sop      <= 1'b0;
      rd_eop      <= 1'b0;
      hdr_rdreq   <= 1'b0;
      wvb_rddone  <= 1'b0;
    end else begin
      rd_vld     <= adv;
      rd_sop     <= first;
      rd_eop     <= stop_hit;
      hdr_rdreq  <= 1'b0;
      wvb_rddone <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (en && !hdr_empty) begin
            evt_hdr     <= hdr_data;
            wvb_rd_addr <= P_ADR_WIDTH'(in_start);
            first       <= 1'b1;
            state       <= S_READ;
          end
        end
        S_READ: begin
          if (adv) begin
            wvb_rd_addr <= wvb_rd_addr + P_ADR_WIDTH'(1);
            first       <= 1'b0;
            if (stop_hit) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && out_eop) begin
            hdr_rdreq  <= 1'b1;
            wvb_rddone <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wvb_reader.sv
// Self-checking bench for wvb_reader: RAM and header FIFO models,
// vector table, reset and back-to-back sequences.
module tb_wvb_reader;

  typedef struct packed {
    logic [21:0] data;
    logic        sop;
    logic        eop;
  } smp_t;

  typedef struct {
    logic [11:0] start;
    logic [11:0] stop;
    bit          rnd;
    bit          drop;
    int          exp_n;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        hdr_empty = 1'b1;
  logic [79:0] hdr_data = '0;
  logic        hdr_rdreq;
  logic [11:0] wvb_rd_addr;
  logic [21:0] wvb_data = '0;
  logic        wvb_rddone;
  logic [79:0] evt_hdr;
  logic [21:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sop;
  logic        out_eop;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int rdreq_cnt = 0;
  int fv_cyc = 0;
  bit rnd_ready = 1'b0;
  bit stall_prev = 1'b0;
  logic [23:0] stall_v = '0;
  logic [79:0] prev_hdr = '0;

  logic [21:0] mem [4096];
  logic [79:0] hq [$];
  smp_t        rx [$];
  smp_t        exq [$];
  int          leave_q [$];
  int          done_q [$];
  vec_t        vt [10];

  wvb_reader dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .hdr_empty   (hdr_empty),
    .hdr_data    (hdr_data),
    .hdr_rdreq   (hdr_rdreq),
    .wvb_rd_addr (wvb_rd_addr),
    .wvb_data    (wvb_data),
    .wvb_rddone  (wvb_rddone),
    .evt_hdr     (evt_hdr),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sop     (out_sop),
    .out_eop     (out_eop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    wvb_data <= mem[wvb_rd_addr];
  end

  task automatic chk(input bit ok, input string nm,
                     input logic [95:0] act,
                     input logic [95:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Monitor, ready driver and header FIFO model, all off the clock edge.
  always @(negedge clk) begin
    out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (stall_prev && !rst)
      chk(out_valid && {out_data, out_sop, out_eop} == stall_v,
          "hold", {out_valid, out_data, out_sop, out_eop},
          {1'b1, stall_v});
    stall_prev = out_valid && !out_ready && !rst;
    stall_v = {out_data, out_sop, out_eop};
    if (out_valid && out_ready && !rst)
      rx.push_back({out_data, out_sop, out_eop});
    if (!rst && evt_hdr != prev_hdr) begin
      leave_q.push_back(cyc);
      fv_cyc = -1;
    end
    prev_hdr = evt_hdr;
    if (out_valid && fv_cyc < 0) fv_cyc = cyc;
    if (wvb_rddone || hdr_rdreq)
      chk(wvb_rddone == hdr_rdreq, "pulse_pair",
          {wvb_rddone, hdr_rdreq}, 2'b11);
    if (wvb_rddone) begin
      chk(!hdr_empty && evt_hdr == hdr_data, "fifo_head",
          hdr_data, evt_hdr);
      done_cnt++;
      done_q.push_back(cyc);
    end
    if (hdr_rdreq) begin
      rdreq_cnt++;
      if (hq.size() > 0) void'(hq.pop_front());
    end
    hdr_empty = (hq.size() == 0);
    hdr_data  = hdr_empty ? '0 : hq[0];
  end

  function automatic logic [79:0] mk_hdr(input int id,
                                         input logic [11:0] s,
                                         input logic [11:0] e);
    logic [31:0] r;
    r = $urandom;
    return {16'(id + 1), r, s, e, r[1:0], r[2], r[7:3]};
  endfunction

  // Expected stream straight from the word-count rule.
  task automatic add_exp(input logic [11:0] s, input logic [11:0] e);
    int n;
    n = int'(12'(e - s + 12'd1));
    if (n == 0) n = 4096;
    for (int i = 0; i < n; i++)
      exq.push_back({mem[(int'(s) + i) % 4096], i == 0, i == n - 1});
  endtask

  task automatic cmp_stream(input string nm);
    int bad;
    smp_t g;
    smp_t w;
    bad = -1;
    g = '0;
    w = '0;
    chk(rx.size() == exq.size(), {nm, "_count"},
        rx.size(), exq.size());
    for (int i = 0; i < rx.size() && i < exq.size(); i++)
      if (bad < 0 && rx[i] != exq[i]) begin
        bad = i;
        g = rx[i];
        w = exq[i];
      end
    chk(bad < 0, {nm, "_stream"}, {32'(bad), g}, {32'(bad), w});
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 10000 && done_cnt < target; k++)
      @(negedge clk);
  endtask

  task automatic run_vec(input int id, input vec_t t);
    logic [79:0] h;
    int d0;
    int l0;
    int lv;
    rx.delete();
    exq.delete();
    rnd_ready = t.rnd;
    add_exp(t.start, t.stop);
    h = mk_hdr(id, t.start, t.stop);
    d0 = done_cnt;
    l0 = leave_q.size();
    @(posedge clk);
    #1 hq.push_back(h);
    for (int k = 0; k < 10000 && done_cnt == d0; k++) begin
      @(negedge clk);
      if (t.drop && leave_q.size() > l0) en = 1'b0;
    end
    en = 1'b1;
    chk(done_cnt == d0 + 1, "done", done_cnt - d0, 1);
    chk(rx.size() == t.exp_n, "len", rx.size(), t.exp_n);
    cmp_stream($sformatf("vec%0d", id));
    chk(evt_hdr == h, "evt_hdr", evt_hdr, h);
    if (!t.rnd && leave_q.size() > l0 && done_cnt > d0) begin
      lv = leave_q[l0];
      chk(fv_cyc >= lv && fv_cyc - lv <= 3, "first_lat",
          fv_cyc - lv, 3);
      chk(done_q[done_q.size() - 1] - lv <= t.exp_n + 3, "thruput",
          done_q[done_q.size() - 1] - lv, t.exp_n + 3);
    end
    @(negedge clk);
  endtask

  initial begin
    int d0;
    int r0;
    int l0;
    int dq0;
    logic [79:0] h1;
    logic [79:0] h2;
    vec_t tv;

    for (int i = 0; i < 4096; i++) mem[i] = 22'($urandom);
    vt[0] = '{12'h010, 12'h013, 1'b0, 1'b0, 4};
    vt[1] = '{12'hFFE, 12'h001, 1'b0, 1'b0, 4};
    vt[2] = '{12'h005, 12'h004, 1'b0, 1'b0, 4096};
    vt[3] = '{12'h200, 12'h200, 1'b1, 1'b0, 1};
    vt[4] = '{12'h7F0, 12'h80F, 1'b1, 1'b1, 32};
    for (int i = 5; i < 10; i++) begin
      int len;
      len = 1 + $urandom_range(0, 47);
      vt[i].start = 12'($urandom);
      vt[i].stop  = vt[i].start + 12'(len - 1);
      vt[i].rnd   = 1'($urandom_range(0, 1));
      vt[i].drop  = 1'($urandom_range(0, 1));
      vt[i].exp_n = len;
    end

    repeat (3) @(posedge clk);
    #1;
    chk(out_valid == 1'b0, "rst_valid", out_valid, 0);
    chk({hdr_rdreq, wvb_rddone} == 2'b00, "rst_pulses",
        {hdr_rdreq, wvb_rddone}, 0);
    chk(wvb_rd_addr == 12'h000, "rst_addr", wvb_rd_addr, 0);
    chk(evt_hdr == '0, "rst_hdr", evt_hdr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(i, vt[i]);

    // Reset in the middle of an 8-word event.
    rx.delete();
    exq.delete();
    rnd_ready = 1'b0;
    d0 = done_cnt;
    r0 = rdreq_cnt;
    @(posedge clk);
    #1 hq.push_back(mk_hdr(100, 12'h100, 12'h107));
    for (int k = 0; k < 100 && rx.size() < 3; k++) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk(out_valid == 1'b0, "midrst_valid", out_valid, 0);
    chk({out_sop, out_eop} == 2'b00, "midrst_flags",
        {out_sop, out_eop}, 0);
    chk(evt_hdr == '0 && wvb_rd_addr == '0, "midrst_regs",
        {evt_hdr, wvb_rd_addr}, 0);
    hq.delete();
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk(done_cnt == d0, "midrst_done", done_cnt - d0, 0);
    chk(rdreq_cnt == r0, "midrst_rdreq", rdreq_cnt - r0, 0);
    tv = '{12'h300, 12'h307, 1'b0, 1'b0, 8};
    run_vec(101, tv);

    // Two queued headers stream back to back.
    rx.delete();
    exq.delete();
    rnd_ready = 1'b0;
    add_exp(12'h040, 12'h045);
    add_exp(12'hFFC, 12'h002);
    h1 = mk_hdr(102, 12'h040, 12'h045);
    h2 = mk_hdr(103, 12'hFFC, 12'h002);
    d0 = done_cnt;
    r0 = rdreq_cnt;
    l0 = leave_q.size();
    dq0 = done_q.size();
    @(posedge clk);
    #1;
    hq.push_back(h1);
    hq.push_back(h2);
    wait_done(d0 + 2);
    chk(done_cnt == d0 + 2, "b2b_done", done_cnt - d0, 2);
    chk(rdreq_cnt == r0 + 2, "b2b_rdreq", rdreq_cnt - r0, 2);
    cmp_stream("b2b");
    if (leave_q.size() >= l0 + 2 && done_q.size() >= dq0 + 1)
      chk(leave_q[l0 + 1] - done_q[dq0] == 2, "b2b_gap",
          leave_q[l0 + 1] - done_q[dq0], 2);
    else
      chk(1'b0, "b2b_gap_seen", leave_q.size() - l0, 2);
    chk(evt_hdr == h2, "b2b_hdr", evt_hdr, h2);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wvb_reader.md
WVB_READER -- requirements
Module: wvb_reader

Interface
REQ-001 Parameter P_ADR_WIDTH, default 12, waveform buffer address width.
REQ-002 Parameter P_HDR_WIDTH, default 80, header bundle width (evt_ltc 48, start_addr 12, stop_addr 12, trig_src 2, cnst_run 1, pre_conf 5).
REQ-003 Parameter P_DATA_WIDTH, default 22, waveform buffer word width.
REQ-004 Port clk, input, 1, clock; all logic on its rising edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port en, input, 1, permits starting a new event.
REQ-007 Port hdr_empty, input, 1, header FIFO empty.
REQ-008 Port hdr_data, input, P_HDR_WIDTH, show-ahead header FIFO head, valid when hdr_empty=0.
REQ-009 Port hdr_rdreq, output, 1, one-cycle pop of header FIFO.
REQ-010 Port wvb_rd_addr, output, P_ADR_WIDTH, buffer read address.
REQ-011 Port wvb_data, input, P_DATA_WIDTH, buffer read data, exactly 1 cycle after wvb_rd_addr.
REQ-012 Port wvb_rddone, output, 1, one-cycle pulse: event fully read, buffer space released.
REQ-013 Port evt_hdr, output, P_HDR_WIDTH, header of the event being streamed.
REQ-014 Port out_data, output, P_DATA_WIDTH, sample stream data.
REQ-015 Port out_valid / out_ready, output / input, 1 each, stream handshake; transfer when both high.
REQ-016 Port out_sop / out_eop, output, 1 each, first / last sample of event, qualified by out_valid.

Function
REQ-017 The block SHALL implement states IDLE, READ, DRAIN, DONE.
REQ-018 IDLE -> READ when en=1 and hdr_empty=0; same edge latches hdr_data into evt_hdr and sets wvb_rd_addr=start_addr.
REQ-019 In READ the block SHALL issue one address per cycle, incrementing modulo 2^P_ADR_WIDTH, only while the output buffer has space for every in-flight word.
REQ-020 Word count SHALL be (stop_addr - start_addr + 1) mod 2^P_ADR_WIDTH, with 0 meaning 2^P_ADR_WIDTH words (full buffer); start_addr==stop_addr yields 1 word.
REQ-021 READ -> DRAIN after the address equal to stop_addr is issued.
REQ-022 DRAIN -> DONE on the cycle the out_eop word is transferred.
REQ-023 DONE SHALL last one cycle, asserting wvb_rddone and hdr_rdreq together, then return to IDLE.
REQ-024 hdr_data SHALL be untouched (no pop) until DONE, so the header FIFO head matches the event at wvb_rddone.
REQ-025 Samples SHALL be emitted in address order, none lost or duplicated, under any out_ready pattern.
REQ-026 out_data/out_sop/out_eop SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 out_sop SHALL mark the start_addr word, out_eop the stop_addr word; both on a single-word event.
REQ-028 With out_ready held 1, sustained throughput SHALL be one sample per cycle; first out_valid no later than 3 cycles after leaving IDLE.
REQ-029 en=0 mid-event SHALL NOT abort the event; en only gates IDLE exit.
REQ-030 evt_hdr SHALL hold its value from latch until the next IDLE exit.
REQ-031 Minimum gap between consecutive events SHALL be 2 cycles (DONE + IDLE).

Reset
REQ-032 rst SHALL force IDLE, hdr_rdreq=0, wvb_rddone=0, out_valid=0, out_sop=0, out_eop=0, wvb_rd_addr=0, evt_hdr=0, and empty the output buffer.
REQ-033 rst mid-event SHALL abandon the event without pulsing wvb_rddone or hdr_rdreq.

Structure
REQ-034 Header field widths and bit offsets SHALL live in the shared waveform-buffer package; header decode SHALL use mDOM_wvb_hdr_bundle_0_fan_out.
REQ-035 The output buffer SHALL be a sub-module wvb_rd_skid (2-entry valid/ready skid buffer absorbing RAM latency).

Verification
REQ-036 start=0x010, stop=0x013, out_ready=1 -> 4 samples from addr 0x010..0x013, sop on first, eop on fourth, one wvb_rddone+hdr_rdreq pulse.
REQ-037 start=0xFFE, stop=0x001 -> 4 samples from 0xFFE,0xFFF,0x000,0x001 in order.
REQ-038 start=0x005, stop=0x004 -> 4096 samples, eop on the 4096th only.
REQ-039 start=stop=0x200, out_ready random 50% -> single sample with sop=eop=1, data stable while stalled.
REQ-040 rst asserted mid-READ of 8-word event -> no wvb_rddone, no hdr_rdreq, out_valid=0 next cycle; next event read correctly.
REQ-041 Two headers queued, en=1, out_ready=1 -> back-to-back events, 2-cycle gap, two rddone pulses each coincident with hdr_rdreq.
